stream_mux_n: RTL and testbench
===============================

Name: stream_mux_n

Overview:
- Parametrised N:1 multi-bit stream multiplexer with per-channel valid/ready handshake and a registered output stage.
- Generalises the 16x1 single-bit select mux in three ways: configurable channel count and data width, a fixed-select or round-robin arbitration mode, and backpressure.
- Sits between N producer channels and one consumer.
- Output is registered: one cycle latency, full throughput.

Parameters:
- NUM_IN, 16, number of input channels (>=2).
- DATA_W, 8, bits per channel.
- SEL_W, $clog2(NUM_IN), select/channel-index width. Derived localparam; not overridden.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- mode  in  1  0 = fixed select (sel), 1 = round-robin over valid channels.
- sel  in  SEL_W  channel index used when mode=0.
- in_valid  in  NUM_IN  per-channel data valid.
- in_data  in  NUM_IN*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  NUM_IN  per-channel accept; at most one bit high.
- out_valid  out  1  output register holds data.
- out_data  out  DATA_W  registered data.
- out_chan  out  SEL_W  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - out_valid=0, out_data=0, out_chan=0, rr_ptr=NUM_IN-1, so channel 0 has first priority.
  - While rstn=0, in_ready is all-zero (combinational gate).
  - Reset mid-transfer discards held data; nothing is replayed.
- Load enable: load_en = !out_valid || out_ready. The register accepts new data while empty or in the same cycle it drains. This gives one beat per cycle with no bubble.
- Grant, combinational each cycle:
  - mode=0: grant=sel when sel<NUM_IN. If sel>=NUM_IN (possible only for non-power-of-two NUM_IN), there is no grant and in_ready is all-zero.
  - mode=0: in_ready[sel]=load_en regardless of in_valid[sel].
  - mode=1: grant is the first i with in_valid[i]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_IN, wrapping from NUM_IN-1 to 0. No valid channel means no grant.
  - mode=1: in_ready[grant]=load_en only when a grant exists.
- Transfer on channel g: in_valid[g] && in_ready[g]. At the next edge:
  - out_data <= in_data[g], out_chan <= g, out_valid <= 1.
  - In mode=1, rr_ptr <= g. rr_ptr is unchanged in mode=0 and on cycles with no transfer.
- Drain without refill: out_valid && out_ready && no transfer -> out_valid <= 0. out_data and out_chan hold their last value.
- Stall: out_valid && !out_ready -> out_data and out_chan stable, all in_ready=0.
- Mode or sel changes take effect on the next grant evaluation. Data already in the register is unaffected.
- Fairness: in mode=1 with all channels continuously valid and out_ready=1, grants are 0,1,...,NUM_IN-1,0,... with one beat per cycle.
- No combinational path from in_data to out_data.
- Paths exist from out_ready and in_valid to in_ready (documented; accepted).

Decomposition:
- Package mux_pkg:
  - default constants IN_LENGTH=16, SEL_LENGTH=4;
  - mux_mode_e enum {MODE_FIXED=1'b0, MODE_RR=1'b1};
  - function for the ceiling-log2 of the channel count.
- Sub-module mux_rr_pick(NUM_IN): inputs req[NUM_IN], ptr[SEL_W]; outputs gnt_vld, gnt_idx[SEL_W]. Purely combinational rotate, priority-encode, un-rotate.
- Top holds the output register, rr_ptr, the load-enable and in_ready logic, and the data select.

Test Plan:
- Reset, then mode=0, sel=5, in_valid[5]=1, in_data[5]=8'hA5, out_ready=1 -> in_ready=16'h0020; next cycle out_valid=1, out_data=8'hA5, out_chan=5.
- mode=1, all 16 in_valid=1, in_data[i]=i, out_ready=1 for 20 cycles -> out_chan sequence 0..15,0,1,2,3 with no bubbles; out_data equals out_chan.
- mode=1, only channels 3 and 12 valid, rr_ptr=3 -> grants 12,3,12,3 alternating; in_ready never set for an invalid channel.
- Backpressure: register full, out_ready=0 for 4 cycles -> in_ready=0, out_data stable. out_ready returns with a new valid beat present -> drain and refill in the same cycle, out_valid stays 1.
- Drive rstn=0 for one edge while out_valid=1 and rr_ptr=7 -> next cycle out_valid=0, out_data=0, out_chan=0; with all channels valid in mode=1, first grant is channel 0.
- NUM_IN=5, DATA_W=12: mode=0, sel=6 -> in_ready=0, out_valid stays 0. Round-robin wraps 4->0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants, mode encoding and width helper for the stream_mux_n block.
package mux_pkg;

    localparam int IN_LENGTH  = 16;
    localparam int SEL_LENGTH = 4;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    function automatic int clog2_n(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/stream_mux_n_if.sv
// Producer/consumer side bundle of the N:1 stream mux; clk and rstn stay outside.
interface stream_mux_n_if
    import mux_pkg::*;
#(
    parameter int NUM_IN = IN_LENGTH,
    parameter int DATA_W = 8
) ();
    localparam int SEL_W = clog2_n(NUM_IN);

    mux_mode_e                  mode;
    logic [SEL_W-1:0]           sel;
    logic [NUM_IN-1:0]          in_valid;
    logic [NUM_IN*DATA_W-1:0]   in_data;
    logic [NUM_IN-1:0]          in_ready;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic [SEL_W-1:0]           out_chan;
    logic                       out_ready;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/mux_rr_pick.sv
// Round-robin picker: first requester strictly after ptr, wrapping modulo NUM_IN.
module mux_rr_pick
    import mux_pkg::*;
#(
    parameter int NUM_IN = IN_LENGTH,
    localparam int SEL_W = clog2_n(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              gnt_vld,
    output logic [SEL_W-1:0]  gnt_idx
);
    localparam logic [SEL_W:0] ONE   = (SEL_W+1)'(1);
    localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(NUM_IN);

    logic [2*NUM_IN-1:0] w_dbl;
    logic [NUM_IN-1:0]   w_rot;
    logic                w_hit;
    logic [SEL_W:0]      w_off;
    logic [SEL_W:0]      w_sum;

    // Shift by ptr+1 (never more than NUM_IN) so bit 0 of w_rot is the next channel.
    assign w_dbl = {req, req} >> ({1'b0, ptr} + ONE);
    assign w_rot = w_dbl[NUM_IN-1:0];

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        w_hit = 1'b0;
        w_off = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_hit = 1'b1;
                w_off = (SEL_W+1)'(k);
            end
        end
    end

    assign w_sum   = {1'b0, ptr} + ONE + w_off;
    assign gnt_vld = w_hit;
    assign gnt_idx = (w_sum >= N_EXT) ? SEL_W'(w_sum - N_EXT) : SEL_W'(w_sum);

endmodule

// File: rtl/stream_mux_n.sv
// N:1 valid/ready stream mux with fixed-select or round-robin grant and a registered output.
module stream_mux_n
    import mux_pkg::*;
#(
    parameter int NUM_IN = IN_LENGTH,
    parameter int DATA_W = 8,
    localparam int SEL_W = clog2_n(NUM_IN)
) (
    input  logic           clk,
    input  logic           rstn,
    stream_mux_n_if.slave  bus
);
    localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(NUM_IN);

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [SEL_W-1:0]    r_out_chan;
    logic [SEL_W-1:0]    r_rr_ptr;

    logic                w_load_en;
    logic                w_rr_vld;
    logic [SEL_W-1:0]    w_rr_idx;
    logic                w_gnt_vld;
    logic [SEL_W-1:0]    w_gnt_idx;
    logic [NUM_IN-1:0]   w_in_ready;
    logic [DATA_W-1:0]   w_gnt_data;
    logic                w_xfer;

    mux_rr_pick #(.NUM_IN(NUM_IN)) u_pick (
        .req     (bus.in_valid),
        .ptr     (r_rr_ptr),
        .gnt_vld (w_rr_vld),
        .gnt_idx (w_rr_idx)
    );

    // Accept while empty or in the same cycle the consumer drains: no bubble.
    assign w_load_en = !r_out_valid || bus.out_ready;

    always_comb begin
        if (bus.mode == MODE_RR) begin
            w_gnt_vld = w_rr_vld;
            w_gnt_idx = w_rr_idx;
        end else begin
            w_gnt_vld = ({1'b0, bus.sel} < N_EXT);
            w_gnt_idx = bus.sel;
        end
    end

    always_comb begin
        w_in_ready = '0;
        w_gnt_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_gnt_idx == SEL_W'(i)) begin
                w_in_ready[i] = rstn && w_gnt_vld && w_load_en;
                w_gnt_data    = bus.in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_xfer = |(bus.in_valid & w_in_ready);

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_rr_ptr    <= SEL_W'(NUM_IN - 1);
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_chan  <= w_gnt_idx;
            if (bus.mode == MODE_RR) r_rr_ptr <= w_gnt_idx;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_chan  = r_out_chan;

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n: 16x8 instance for the main behaviour, 5x12 for non-power-of-two.
module tb_stream_mux_n;
    import mux_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    stream_mux_n_if #(.NUM_IN(16), .DATA_W(8))  a_if ();
    stream_mux_n_if #(.NUM_IN(5),  .DATA_W(12)) b_if ();

    stream_mux_n #(.NUM_IN(16), .DATA_W(8)) u_dut_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (a_if.slave)
    );

    stream_mux_n #(.NUM_IN(5), .DATA_W(12)) u_dut_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (b_if.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [15:0] e16;
        logic [4:0]  e5;
        int          g;

        a_if.mode = MODE_FIXED; a_if.sel = '0; a_if.in_valid = '0; a_if.in_data = '0; a_if.out_ready = 1'b0;
        b_if.mode = MODE_FIXED; b_if.sel = '0; b_if.in_valid = '0; b_if.in_data = '0; b_if.out_ready = 1'b0;

        // Reset: in_ready must be gated even with a valid, selected channel and load_en high.
        rstn = 1'b0;
        a_if.in_valid  = '1;
        a_if.out_ready = 1'b1;
        b_if.in_valid  = '1;
        b_if.out_ready = 1'b1;
        step(); step();
        check("rst_in_ready_a", 64'(a_if.in_ready), 64'h0);
        check("rst_in_ready_b", 64'(b_if.in_ready), 64'h0);
        check("rst_out_valid",  64'(a_if.out_valid), 64'h0);
        check("rst_out_data",   64'(a_if.out_data),  64'h0);
        check("rst_out_chan",   64'(a_if.out_chan),  64'h0);
        a_if.in_valid = '0;
        b_if.in_valid = '0;
        rstn = 1'b1;

        // Fixed select, channel 5.
        a_if.sel = 4'd5;
        a_if.in_valid = 16'h0020;
        a_if.in_data[5*8 +: 8] = 8'hA5;
        settle();
        check("fix_in_ready", 64'(a_if.in_ready), 64'h0020);
        step();
        check("fix_out_valid", 64'(a_if.out_valid), 64'h1);
        check("fix_out_data",  64'(a_if.out_data),  64'hA5);
        check("fix_out_chan",  64'(a_if.out_chan),  64'h5);
        a_if.in_valid = '0;
        settle();
        check("fix_rdy_no_valid", 64'(a_if.in_ready), 64'h0020);
        step();
        check("drain_valid", 64'(a_if.out_valid), 64'h0);
        check("drain_hold",  64'(a_if.out_data),  64'hA5);

        // Round-robin with every channel valid: 0..15,0..3, one beat per cycle.
        a_if.mode = MODE_RR;
        a_if.in_valid = '1;
        for (int i = 0; i < 16; i++) a_if.in_data[i*8 +: 8] = 8'(i);
        for (int i = 0; i < 20; i++) begin
            e16 = 16'd1 << (i % 16);
            settle();
            check("rr_all_rdy", 64'(a_if.in_ready), 64'(e16));
            step();
            check("rr_all_valid", 64'(a_if.out_valid), 64'h1);
            check("rr_all_chan",  64'(a_if.out_chan),  64'(i % 16));
            check("rr_all_data",  64'(a_if.out_data),  64'(i % 16));
        end

        // Only 3 and 12 valid, pointer at 3: 12,3,12,3.
        a_if.in_valid = '0;
        a_if.in_valid[3]  = 1'b1;
        a_if.in_valid[12] = 1'b1;
        a_if.in_data[3*8 +: 8]  = 8'h33;
        a_if.in_data[12*8 +: 8] = 8'hCC;
        for (int k = 0; k < 4; k++) begin
            g = (k % 2 == 0) ? 12 : 3;
            e16 = 16'd1 << g;
            settle();
            check("rr_two_rdy", 64'(a_if.in_ready), 64'(e16));
            step();
            check("rr_two_chan", 64'(a_if.out_chan), 64'(g));
            check("rr_two_data", 64'(a_if.out_data), (g == 12) ? 64'hCC : 64'h33);
        end

        // Backpressure: register holds channel 3 beat.
        a_if.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("stall_rdy", 64'(a_if.in_ready), 64'h0);
            step();
            check("stall_valid", 64'(a_if.out_valid), 64'h1);
            check("stall_data",  64'(a_if.out_data),  64'h33);
            check("stall_chan",  64'(a_if.out_chan),  64'h3);
        end
        a_if.out_ready = 1'b1;
        settle();
        check("refill_rdy", 64'(a_if.in_ready), 64'h1000);
        step();
        check("refill_valid", 64'(a_if.out_valid), 64'h1);
        check("refill_data",  64'(a_if.out_data),  64'hCC);
        check("refill_chan",  64'(a_if.out_chan),  64'hC);

        // Move pointer to 7, then reset with data held.
        a_if.in_valid = 16'h0080;
        a_if.in_data[7*8 +: 8] = 8'h77;
        a_if.in_data[0*8 +: 8] = 8'h5A;
        settle();
        check("ptr7_rdy", 64'(a_if.in_ready), 64'h0080);
        step();
        check("ptr7_chan", 64'(a_if.out_chan), 64'h7);
        a_if.in_valid = '1;
        rstn = 1'b0;
        settle();
        check("midrst_rdy", 64'(a_if.in_ready), 64'h0);
        step();
        rstn = 1'b1;
        check("midrst_valid", 64'(a_if.out_valid), 64'h0);
        check("midrst_data",  64'(a_if.out_data),  64'h0);
        check("midrst_chan",  64'(a_if.out_chan),  64'h0);
        settle();
        check("postrst_rdy", 64'(a_if.in_ready), 64'h0001);
        step();
        check("postrst_chan", 64'(a_if.out_chan), 64'h0);
        check("postrst_data", 64'(a_if.out_data), 64'h5A);

        // NUM_IN=5: out-of-range select grants nothing.
        b_if.in_valid = '1;
        for (int i = 0; i < 5; i++) b_if.in_data[i*12 +: 12] = 12'h100 + 12'(i);
        b_if.mode = MODE_FIXED;
        b_if.sel  = 3'd6;
        settle();
        check("b_sel6_rdy", 64'(b_if.in_ready), 64'h0);
        step();
        check("b_sel6_valid", 64'(b_if.out_valid), 64'h0);
        b_if.sel = 3'd7;
        settle();
        check("b_sel7_rdy", 64'(b_if.in_ready), 64'h0);
        step();
        check("b_sel7_valid", 64'(b_if.out_valid), 64'h0);
        b_if.sel = 3'd4;
        settle();
        check("b_sel4_rdy", 64'(b_if.in_ready), 64'h10);
        step();
        check("b_sel4_chan", 64'(b_if.out_chan), 64'h4);
        check("b_sel4_data", 64'(b_if.out_data), 64'h104);

        // Round-robin from reset pointer 4: 0,1,2,3,4,0,1.
        b_if.mode = MODE_RR;
        for (int i = 0; i < 7; i++) begin
            e5 = 5'd1 << (i % 5);
            settle();
            check("b_rr_rdy", 64'(b_if.in_ready), 64'(e5));
            step();
            check("b_rr_chan", 64'(b_if.out_chan), 64'(i % 5));
            check("b_rr_data", 64'(b_if.out_data), 64'h100 + 64'(i % 5));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
